// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples spi_clk/cs/mosi into clk, shifts in one MSB-first word per cs-low frame
// and returns tx_data on miso. Define SPI_SLAVE_LATE_CS_EN to accept a final rising edge that arrives after cs rises.
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]   LAST_BIT     = CNT_W'(DATA_WIDTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_CYCLES = FLUSH_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef SPI_SLAVE_LATE_CS_EN
    , ST_LATE = 2'd3
`endif
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic [FLUSH_W-1:0]     flush_cnt;
  logic                   sclk_s, cs_s, mosi_s, sync_ok;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_WIDTH-2:0]  rx_shift, tx_shift;
  logic [DATA_WIDTH-1:0]  rx_next, tx_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   last_bit;

  logic start_frame, shift_in, shift_tx, word_done, err_set;

  // Synchronizers preset to idle pin levels so reset itself never looks like an edge.
  // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      flush_cnt <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (flush_cnt != FLUSH_CYCLES) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edges are trusted only once the chain holds real pin samples; a cs already low at release is not a frame start.
  assign sync_ok   = (flush_cnt == FLUSH_CYCLES);
  assign sclk_rise = sync_ok &  sclk_s & ~sclk_d;
  assign sclk_fall = sync_ok & ~sclk_s &  sclk_d;
  assign cs_rise   = sync_ok &  cs_s   & ~cs_d;
  assign cs_fall   = sync_ok & ~cs_s   &  cs_d;

  assign last_bit = (bit_cnt == LAST_BIT);
  assign rx_next  = {rx_shift, mosi_s};
  assign tx_next  = {tx_shift, 1'b0};

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: each combinational block assigns defaults first so no path leaves a variable unassigned (no latches).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (cs_fall) next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (sclk_rise && last_bit) begin
          next_state = cs_rise ? ST_IDLE : ST_DONE;
        end else if (cs_rise) begin
`ifdef SPI_SLAVE_LATE_CS_EN
          next_state = last_bit ? ST_LATE : ST_IDLE;
`else
          next_state = ST_IDLE;
`endif
        end
      end
      ST_DONE: if (cs_rise) next_state = ST_IDLE;
`ifdef SPI_SLAVE_LATE_CS_EN
      ST_LATE: begin
        if (sclk_rise)    next_state = ST_IDLE;
        else if (cs_fall) next_state = ST_SHIFT;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    shift_in    = 1'b0;
    shift_tx    = 1'b0;
    word_done   = 1'b0;
    err_set     = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_IDLE: start_frame = cs_fall;
      ST_SHIFT: begin
        busy = 1'b1;
        // The final bit wins over a simultaneous cs rise; any earlier cs rise aborts the frame.
        if (sclk_rise && last_bit) begin
          shift_in  = 1'b1;
          word_done = 1'b1;
        end else if (cs_rise) begin
`ifdef SPI_SLAVE_LATE_CS_EN
          err_set = !last_bit;
`else
          err_set = 1'b1;
`endif
        end else begin
          shift_in = sclk_rise;
          shift_tx = sclk_fall && (bit_cnt != '0);
        end
      end
      ST_DONE: busy = 1'b1;
`ifdef SPI_SLAVE_LATE_CS_EN
      ST_LATE: begin
        busy = 1'b1;
        if (sclk_rise) begin
          word_done = 1'b1;
        end else if (cs_fall) begin
          err_set     = 1'b1;
          start_frame = 1'b1;
        end
      end
`endif
      default: busy = 1'b0;
    endcase
  end

  // tx_shift holds the bits still to send after the one currently on miso.
  always_ff @(posedge clk) begin
    if (!reset) begin
      miso      <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      bit_cnt   <= '0;
    end else begin
      rx_valid  <= word_done;
      frame_err <= err_set;

      if (start_frame) begin
        tx_shift <= tx_data[DATA_WIDTH-2:0];
        bit_cnt  <= '0;
      end else begin
        if (shift_in) begin
          rx_shift <= rx_next[DATA_WIDTH-2:0];
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (shift_tx) tx_shift <= tx_next[DATA_WIDTH-2:0];
      end

      if (word_done) rx_data <= rx_next;

      if (start_frame)                 miso <= tx_data[DATA_WIDTH-1];
      else if (shift_tx)               miso <= tx_next[DATA_WIDTH-1];
      else if (next_state != ST_SHIFT) miso <= 1'b1;
    end
  end

endmodule
